// File: rtl/nios_system_ram_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_ram_loader_if
// Description : Groups the loader's byte-stream sink and its single-port RAM
//               bus. The master modport is the loader's view, and the slave
//               modport is the view of the stream source and the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface nios_system_ram_loader_if #(
  parameter int ADDR_W = 10
);
  // Avalon-ST byte sink
  logic [7:0]        snk_data;
  logic              snk_valid;
  logic              snk_eop;
  logic              snk_ready;
  // Single-port RAM bus
  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [31:0]       ram_writedata;
  logic              ram_clken;
  logic [31:0]       ram_readdata;

  modport master (
    input  snk_data, snk_valid, snk_eop, ram_readdata,
    output snk_ready, ram_address, ram_byteenable, ram_chipselect,
           ram_write, ram_writedata, ram_clken
  );

  modport slave (
    output snk_data, snk_valid, snk_eop, ram_readdata,
    input  snk_ready, ram_address, ram_byteenable, ram_chipselect,
           ram_write, ram_writedata, ram_clken
  );
endinterface
`default_nettype wire

// File: rtl/nios_system_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_ram_loader
// Description : Boot loader for the 1024x32 program/data RAM. It packs an
//               8-bit stream little-endian into 32-bit words and writes each
//               word with byte enables. It also tracks the word count and a
//               16-bit byte checksum.
//               Optional read-back verify: define RAM_LOADER_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nios_system_ram_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  nios_system_ram_loader_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_W:0]         word_count,
  output logic [15:0]             checksum
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_WRITE  = 3'd2,
`ifdef RAM_LOADER_VERIFY_EN
    ST_VERIFY = 3'd3,
`endif
    ST_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [1:0]        r_lane;
  logic              r_eop_word;
  logic [ADDR_W:0]   r_word_count;
  logic [15:0]       r_checksum;
  logic              r_error;

  logic              w_start_ok;
  logic              w_accept;
  logic              w_word_full;
  logic              w_snk_ready;
  logic              w_cs;
  logic              w_we;
  logic [3:0]        w_be_out;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_busy;
  logic              w_done;

  // Address arithmetic wraps at DEPTH, which need not be a power of two
  function automatic logic [ADDR_W-1:0] f_addr_inc(input logic [ADDR_W-1:0] a);
    return (a == c_LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_accept    = (r_state == ST_FILL) && bus.snk_valid;
  assign w_word_full = w_accept && (r_lane == 2'd3 || bus.snk_eop);

`ifdef RAM_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W:0]   r_rd_cnt;
  logic [15:0]       r_rsum;
  logic              w_rd_issue;
  logic              w_rd_data_valid;
  logic [3:0]        w_lane_mask;
  logic [15:0]       w_rd_bytes;
  logic [15:0]       w_rsum_final;

  // A read is issued each cycle until every written word has been requested.
  // The cycle after the last request carries the final word's data.
  assign w_rd_issue      = (r_rd_cnt != r_word_count);
  assign w_rd_data_valid = (r_rd_cnt != '0);
  assign w_lane_mask     = w_rd_issue ? 4'hF : r_be;
  assign w_rsum_final    = r_rsum + w_rd_bytes;

  // Sum the returned bytes, with lanes the final word never wrote masked off
  always_comb begin
    w_rd_bytes = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_lane_mask[k]) begin
        w_rd_bytes = w_rd_bytes + 16'(bus.ram_readdata[8*k +: 8]);
      end
    end
  end

  // Read-back address, request count and running read-back sum
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr <= '0;
      r_rd_cnt  <= '0;
      r_rsum    <= '0;
    end else if (w_start_ok) begin
      r_rd_addr <= start_addr;
      r_rd_cnt  <= '0;
      r_rsum    <= '0;
    end else if (r_state == ST_VERIFY) begin
      if (w_rd_issue) begin
        r_rd_addr <= f_addr_inc(r_rd_addr);
        r_rd_cnt  <= r_rd_cnt + (ADDR_W+1)'(1);
      end
      if (w_rd_data_valid) begin
        r_rsum <= w_rsum_final;
      end
    end
  end
`else
  logic w_unused_readdata;
  assign w_unused_readdata = ^bus.ram_readdata;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and the state-driven bus outputs
  always_comb begin
    w_next      = r_state;
    w_snk_ready = 1'b0;
    w_cs        = 1'b0;
    w_we        = 1'b0;
    w_be_out    = 4'hF;
    w_ram_addr  = r_addr;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FILL;
      end
      ST_FILL: begin
        w_snk_ready = 1'b1;
        w_busy      = 1'b1;
        if (w_word_full) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_busy   = 1'b1;
        w_cs     = 1'b1;
        w_we     = 1'b1;
        w_be_out = r_be;
        if (r_eop_word) begin
`ifdef RAM_LOADER_VERIFY_EN
          w_next = ST_VERIFY;
`else
          w_next = ST_DONE;
`endif
        end else if (r_addr == c_LAST_ADDR) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_FILL;
        end
      end
`ifdef RAM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        w_busy     = 1'b1;
        w_cs       = w_rd_issue;
        w_ram_addr = r_rd_addr;
        if (!w_rd_issue) w_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        w_done = 1'b1;
        if (start) w_next = ST_FILL;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Word packing, address advance, counters and the sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_lane       <= '0;
      r_eop_word   <= 1'b0;
      r_word_count <= '0;
      r_checksum   <= '0;
      r_error      <= 1'b0;
    end else if (w_start_ok) begin
      r_addr       <= start_addr;
      r_wdata      <= '0;
      r_be         <= '0;
      r_lane       <= '0;
      r_eop_word   <= 1'b0;
      r_word_count <= '0;
      r_checksum   <= '0;
      r_error      <= 1'b0;
    end else if (w_accept) begin
      r_wdata[{r_lane, 3'b000} +: 8] <= bus.snk_data;
      r_be[r_lane] <= 1'b1;
      r_lane       <= r_lane + 2'd1;
      r_eop_word   <= bus.snk_eop;
      r_checksum   <= r_checksum + {8'h00, bus.snk_data};
    end else if (r_state == ST_WRITE) begin
      r_word_count <= r_word_count + (ADDR_W+1)'(1);
      if (!r_eop_word) begin
        if (r_addr == c_LAST_ADDR) begin
          r_error <= 1'b1;
        end else begin
          // r_be is kept after an eop word so the verify pass can mask it
          r_addr <= f_addr_inc(r_addr);
          r_lane <= '0;
          r_be   <= '0;
        end
      end
`ifdef RAM_LOADER_VERIFY_EN
    end else if (r_state == ST_VERIFY && !w_rd_issue) begin
      if (w_rsum_final != r_checksum) r_error <= 1'b1;
`endif
    end
  end

  assign bus.snk_ready      = w_snk_ready;
  assign bus.ram_address    = w_ram_addr;
  assign bus.ram_byteenable = w_be_out;
  assign bus.ram_chipselect = w_cs;
  assign bus.ram_write      = w_we;
  assign bus.ram_writedata  = r_wdata;
  assign bus.ram_clken      = reset_n;

  assign busy       = w_busy;
  assign done       = w_done;
  assign error      = r_error;
  assign word_count = r_word_count;
  assign checksum   = r_checksum;

endmodule
`default_nettype wire
